// File: rtl/memo_game_core_pkg.sv
// Shared types and helpers for the memory-game sequencing core.
`timescale 1ns/1ps
package memo_game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHOW  = 3'd2,
    INPUT = 3'd3,
    CHECK = 3'd4,
    WIN   = 3'd5,
    LOSE  = 3'd6
  } state_e;

  // Right-shifting Galois form of the x^16+x^14+x^13+x^11+1 polynomial.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
  endfunction

  // Bits needed to hold the values 0..n.
  function automatic int val_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Bits needed for a counter running 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/memo_game_core_if.sv
// Player-side bus of the game core: switch/button inputs and status outputs.
`timescale 1ns/1ps
interface memo_game_core_if #(
  parameter int N_SW = 8,
  parameter int RW   = 5,
  parameter int LW   = 2,
  parameter int TW   = 28
);
  logic            enter;
  logic            confirm;
  logic [N_SW-1:0] user_code;
  logic [1:0]      level;
  logic [N_SW-1:0] show_code;
  logic [RW-1:0]   round;
  logic [RW-1:0]   score;
  logic [LW-1:0]   lives_left;
  logic [TW-1:0]   time_left;
  logic [2:0]      state;
  logic            win;
  logic            lose;

  modport master (
    output enter, confirm, user_code, level,
    input  show_code, round, score, lives_left, time_left, state, win, lose
  );

  modport slave (
    input  enter, confirm, user_code, level,
    output show_code, round, score, lives_left, time_left, state, win, lose
  );
endinterface

// File: rtl/memo_game_core_lfsr.sv
// 16-bit Galois LFSR that advances only when asked; reseeded solely by reset.
`timescale 1ns/1ps
module seq_lfsr
  import memo_game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock_50,
  input  logic        reset,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] value_q, value_d;

  always_comb begin
    value_d = step ? lfsr_step(value_q) : value_q;
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) value_q <= SEED;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/memo_game_core.sv
// Memory-game sequencer: show a pseudo-random code, time the answer, score it,
// with retries on a miss until lives run out.
`timescale 1ns/1ps
module memo_game_core
  import memo_game_pkg::*;
#(
  parameter int          N_SW        = 8,
  parameter int          N_ROUNDS    = 16,
  parameter int          LIVES       = 3,
  parameter int          SHOW_CYCLES = 50_000_000,
  parameter int          TIME_LIMIT  = 250_000_000,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input logic clock_50,
  input logic reset,
  memo_game_core_if.slave bus
);

  localparam int RW = val_w(N_ROUNDS);
  localparam int LW = val_w(LIVES);
  localparam int TW = val_w(TIME_LIMIT);
  localparam int CW = cnt_w(SHOW_CYCLES);

  localparam logic [RW-1:0] ROUNDS_WIN = RW'(N_ROUNDS);
  localparam logic [LW-1:0] LIVES_INIT = LW'(LIVES);
  localparam logic [TW-1:0] TIME_INIT  = TW'(TIME_LIMIT);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);

  state_e          state_q, state_d;
  logic            enter_q, confirm_q;
  logic            enter_edge, confirm_edge;
  logic [N_SW-1:0] code_q, code_d;
  logic [N_SW-1:0] answer_q, answer_d;
  logic [N_SW-1:0] show_code_q, show_code_d;
  logic [RW-1:0]   round_q, round_d;
  logic [RW-1:0]   score_q, score_d;
  logic [LW-1:0]   lives_q, lives_d;
  logic [TW-1:0]   time_q, time_d;
  logic [CW-1:0]   show_cnt_q, show_cnt_d;
  logic [1:0]      lvl_q, lvl_d;
  logic            win_q, win_d;
  logic            lose_q, lose_d;
  logic            miss;
  logic            lfsr_step_en;
  logic [15:0]     lfsr_value;

  seq_lfsr #(.SEED(SEED)) u_lfsr (
    .clock_50 (clock_50),
    .reset    (reset),
    .step     (lfsr_step_en),
    .value    (lfsr_value)
  );

  // The _q copies reset high so a button already held at reset release is not a press.
  assign enter_edge   = bus.enter   & ~enter_q;
  assign confirm_edge = bus.confirm & ~confirm_q;

  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    answer_d     = answer_q;
    round_d      = round_q;
    score_d      = score_q;
    lives_d      = lives_q;
    time_d       = '0;
    show_cnt_d   = show_cnt_q;
    lvl_d        = lvl_q;
    win_d        = win_q;
    lose_d       = lose_q;
    miss         = 1'b0;
    lfsr_step_en = 1'b0;

    case (state_q)
      IDLE: begin
        if (enter_edge) state_d = LOAD;
      end
      LOAD: begin
        score_d      = '0;
        round_d      = '0;
        lives_d      = LIVES_INIT;
        win_d        = 1'b0;
        lose_d       = 1'b0;
        lvl_d        = bus.level;
        lfsr_step_en = 1'b1;
        code_d       = N_SW'(lfsr_step(lfsr_value));
        show_cnt_d   = '0;
        state_d      = SHOW;
      end
      SHOW: begin
        if (show_cnt_q == SHOW_LAST) begin
          time_d  = TIME_INIT >> lvl_q;
          state_d = INPUT;
        end else begin
          show_cnt_d = show_cnt_q + 1'b1;
        end
      end
      INPUT: begin
        // A press in the last counted cycle still wins over the timeout.
        if (confirm_edge) begin
          answer_d = bus.user_code;
          state_d  = CHECK;
        end else if (time_q <= TW'(1)) begin
          miss = 1'b1;
        end else begin
          time_d = time_q - 1'b1;
        end
      end
      CHECK: begin
        if (answer_q == code_q) begin
          score_d = score_q + 1'b1;
          round_d = round_q + 1'b1;
          if (round_q + 1'b1 == ROUNDS_WIN) begin
            win_d   = 1'b1;
            state_d = WIN;
          end else begin
            lfsr_step_en = 1'b1;
            code_d       = N_SW'(lfsr_step(lfsr_value));
            show_cnt_d   = '0;
            state_d      = SHOW;
          end
        end else begin
          miss = 1'b1;
        end
      end
      WIN, LOSE: begin
        if (enter_edge) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase

    // Wrong answers and timeouts share one path: lose a life, replay the same code.
    if (miss) begin
      lives_d = lives_q - 1'b1;
      if (lives_q <= LW'(1)) begin
        lose_d  = 1'b1;
        state_d = LOSE;
      end else begin
        show_cnt_d = '0;
        state_d    = SHOW;
      end
    end

    show_code_d = (state_d == SHOW) ? code_d : '0;
  end

  always_ff @(posedge clock_50 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      enter_q     <= 1'b1;
      confirm_q   <= 1'b1;
      code_q      <= '0;
      answer_q    <= '0;
      show_code_q <= '0;
      round_q     <= '0;
      score_q     <= '0;
      lives_q     <= '0;
      time_q      <= '0;
      show_cnt_q  <= '0;
      lvl_q       <= '0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      enter_q     <= bus.enter;
      confirm_q   <= bus.confirm;
      code_q      <= code_d;
      answer_q    <= answer_d;
      show_code_q <= show_code_d;
      round_q     <= round_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      time_q      <= time_d;
      show_cnt_q  <= show_cnt_d;
      lvl_q       <= lvl_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
    end
  end

  assign bus.show_code  = show_code_q;
  assign bus.round      = round_q;
  assign bus.score      = score_q;
  assign bus.lives_left = lives_q;
  assign bus.time_left  = time_q;
  assign bus.state      = state_q;
  assign bus.win        = win_q;
  assign bus.lose       = lose_q;

endmodule

// File: tb/tb_memo_game_core.sv
// Directed bench for memo_game_core with a small game (3 rounds, 2 lives, 4-cycle show, 16-cycle answer window).
`timescale 1ns/1ps
module tb_memo_game_core;

  // Codes produced by the Galois LFSR from seed 16'hACE1 after 1, 2, 3 steps.
  localparam logic [7:0] CODE1 = 8'h70;
  localparam logic [7:0] CODE2 = 8'h38;
  localparam logic [7:0] CODE3 = 8'h9C;

  logic clock_50 = 1'b0;
  logic reset    = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #5 clock_50 = ~clock_50;

  memo_game_core_if #(.N_SW(8), .RW(2), .LW(2), .TW(5)) gif ();

  memo_game_core #(
    .N_SW(8), .N_ROUNDS(3), .LIVES(2), .SHOW_CYCLES(4), .TIME_LIMIT(16), .SEED(16'hACE1)
  ) dut (
    .clock_50 (clock_50),
    .reset    (reset),
    .bus      (gif.slave)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock_50);
  endtask

  task automatic applyStimulus(input logic enter, input logic confirm,
                               input logic [7:0] user_code, input logic [1:0] level);
    gif.enter     = enter;
    gif.confirm   = confirm;
    gif.user_code = user_code;
    gif.level     = level;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  // Enter pulse; returns at the first SHOW cycle.
  task automatic startGame(input logic [1:0] level);
    applyStimulus(1'b1, 1'b0, 8'h00, level);
    tick(1);
    checkOutput("load_state", gif.state, 1);
    applyStimulus(1'b0, 1'b0, 8'h00, level);
    tick(1);
  endtask

  // Called at the first SHOW cycle; returns at the first INPUT cycle.
  task automatic showPhase(input string tag, input logic [7:0] code, input logic [4:0] t0);
    checkOutput({tag, "_show_state"}, gif.state, 2);
    checkOutput({tag, "_show_code"}, gif.show_code, code);
    tick(3);
    checkOutput({tag, "_show_last"}, gif.show_code, code);
    tick(1);
    checkOutput({tag, "_input_state"}, gif.state, 3);
    checkOutput({tag, "_input_time"}, gif.time_left, t0);
    checkOutput({tag, "_input_code0"}, gif.show_code, 0);
  endtask

  // Called at INPUT cycle 1; press on INPUT cycle n, returns one cycle after CHECK.
  task automatic answer(input string tag, input int n, input logic [7:0] code);
    tick(n - 1);
    applyStimulus(1'b1 & 1'b0, 1'b1, code, gif.level);
    tick(1);
    checkOutput({tag, "_check_state"}, gif.state, 4);
    applyStimulus(1'b0, 1'b0, code, gif.level);
    tick(1);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 2'd0);
    tick(2);
    checkOutput("rst_state", gif.state, 0);
    checkOutput("rst_show", gif.show_code, 0);
    checkOutput("rst_lives", gif.lives_left, 0);
    checkOutput("rst_flags", {gif.win, gif.lose}, 0);
    reset = 1'b1;
    tick(1);

    $display("[TB] perfect game");
    startGame(2'd0);
    showPhase("p1", CODE1, 16);
    answer("p1", 3, CODE1);
    checkOutput("p1_score", gif.score, 1);
    checkOutput("p1_round", gif.round, 1);
    showPhase("p2", CODE2, 16);
    answer("p2", 3, CODE2);
    checkOutput("p2_round", gif.round, 2);
    showPhase("p3", CODE3, 16);
    answer("p3", 3, CODE3);
    checkOutput("win_state", gif.state, 5);
    checkOutput("win_flag", gif.win, 1);
    checkOutput("win_score", gif.score, 3);
    checkOutput("win_round", gif.round, 3);
    checkOutput("win_lives", gif.lives_left, 2);
    checkOutput("win_show", gif.show_code, 0);

    $display("[TB] wrong then right");
    doReset();
    startGame(2'd0);
    checkOutput("wr_win_cleared", gif.win, 0);
    showPhase("wr1", CODE1, 16);
    answer("wr1", 3, CODE1 ^ 8'h01);
    checkOutput("wr1_lives", gif.lives_left, 1);
    checkOutput("wr1_round", gif.round, 0);
    checkOutput("wr1_score", gif.score, 0);
    showPhase("wr2", CODE1, 16);
    answer("wr2", 3, CODE1);
    checkOutput("wr2_lives", gif.lives_left, 1);
    checkOutput("wr2_round", gif.round, 1);
    checkOutput("wr2_code", gif.show_code, CODE2);

    $display("[TB] double miss");
    doReset();
    startGame(2'd0);
    showPhase("dm1", CODE1, 16);
    answer("dm1", 3, 8'h00);
    checkOutput("dm1_lives", gif.lives_left, 1);
    showPhase("dm2", CODE1, 16);
    tick(15);
    checkOutput("dm_last_state", gif.state, 3);
    checkOutput("dm_last_time", gif.time_left, 1);
    tick(1);
    checkOutput("lose_state", gif.state, 6);
    checkOutput("lose_flag", gif.lose, 1);
    checkOutput("lose_lives", gif.lives_left, 0);
    checkOutput("lose_time", gif.time_left, 0);
    tick(2);
    checkOutput("lose_held", {gif.state, gif.lose}, {3'd6, 1'b1});
    startGame(2'd0);
    checkOutput("regame_lose_cleared", gif.lose, 0);
    checkOutput("regame_lives", gif.lives_left, 2);
    checkOutput("regame_code", gif.show_code, CODE2);

    $display("[TB] level scaling");
    doReset();
    startGame(2'd2);
    showPhase("lv", CODE1, 4);
    tick(3);
    checkOutput("lv_last_time", gif.time_left, 1);
    checkOutput("lv_last_state", gif.state, 3);
    tick(1);
    checkOutput("lv_timeout_state", gif.state, 2);
    checkOutput("lv_timeout_lives", gif.lives_left, 1);
    checkOutput("lv_timeout_code", gif.show_code, CODE1);

    $display("[TB] confirm/timeout collision");
    doReset();
    startGame(2'd0);
    showPhase("co", CODE1, 16);
    answer("co", 16, CODE1);
    checkOutput("co_state", gif.state, 2);
    checkOutput("co_score", gif.score, 1);
    checkOutput("co_lives", gif.lives_left, 2);
    checkOutput("co_code", gif.show_code, CODE2);

    $display("[TB] mid-game reset");
    doReset();
    startGame(2'd0);
    showPhase("mr", CODE1, 16);
    answer("mr", 3, CODE1);
    tick(1);
    checkOutput("mr_pre_state", gif.state, 2);
    reset = 1'b0;
    #1;
    checkOutput("mr_state", gif.state, 0);
    checkOutput("mr_show", gif.show_code, 0);
    checkOutput("mr_counts", {gif.score, gif.round, gif.lives_left}, 0);
    checkOutput("mr_flags", {gif.win, gif.lose}, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    startGame(2'd0);
    checkOutput("mr_restart_code", gif.show_code, CODE1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
